// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: Diff = A - B, one bit per clock,
//   LSB first, through one full-subtractor cell and a borrow flip-flop.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (priority over start)
//   start  request a new subtraction; sampled only in IDLE
//   A, B   minuend / subtrahend, captured on the accepted start edge
//   busy   high while bits are being processed (RUN)
//   done   one-cycle pulse, results valid
//   Diff   A - B modulo 2^WIDTH (registered, held until next completion)
//   Bout   final borrow (unsigned A < B)
//   Ovf    signed overflow of A - B
//
// Handshake: start is honoured only when the block is idle (busy=0, done=0);
// a start seen while busy or done is dropped, not queued. done pulses for
// exactly one cycle when Diff/Bout/Ovf take their new values, and the block
// is idle again on the following cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] part;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic b_next;
  logic last_bit;

  // Full-subtractor cell working on the current LSBs.
  assign a_bit    = sh_a[0];
  assign b_bit    = sh_b[0];
  assign d_bit    = a_bit ^ b_bit ^ borrow;
  assign b_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      part   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a   <= A;
            sh_b   <= B;
            part   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          part   <= {d_bit, part[WIDTH-1:1]};
          borrow <= b_next;
          if (last_bit) begin
            // The current LSBs are the operand sign bits on this edge.
            Diff <= {d_bit, part[WIDTH-1:1]};
            Bout <= b_next;
            Ovf  <= (a_bit != b_bit) && (d_bit != a_bit);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH=8): reset behaviour, basic
//   difference, borrow, signed overflow, handshake robustness, back-to-back
//   starts and reset in the middle of an operation.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int total  = 0;
  int passed = 0;

  // Expected values of the held result registers.
  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout),
    .Ovf   (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Full operation from the negedge before the start edge t0 to the negedge
  // after edge t0+W+1. With noisy=1 the inputs are scrambled and start is
  // re-pulsed during RUN and DONE.
  task automatic do_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                       input logic [W-1:0] rd, input logic rb, input logic ro,
                       input bit noisy);
    a = opa; b = opb; start = 1'b1;
    @(negedge clk);                       // after t0
    start = noisy;
    if (noisy) begin a = '1; b = '1; end
    for (int k = 1; k < W; k++) begin
      @(negedge clk);                     // after t0+k
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("diff_held", diff, exp_diff);
      if (noisy) begin a = a ^ 8'h5A; b = ~b; start = 1'b1; end
    end
    @(negedge clk);                       // after t0+W
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("diff", diff, rd);
    check("bout", bout, rb);
    check("ovf", ovf, ro);
    exp_diff = rd; exp_bout = rb; exp_ovf = ro;
    @(negedge clk);                       // after t0+W+1, IDLE
    start = 1'b0;
    check("done_single", done, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;

    // Reset held for two edges with start high.
    @(negedge clk);
    check("rst_busy1", busy, 1'b0);
    check("rst_done1", done, 1'b0);
    @(negedge clk);
    check("rst_busy2", busy, 1'b0);
    check("rst_done2", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Basic, borrow, signed overflow.
    do_op(8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    do_op(8'h20, 8'h50, 8'hD0, 1'b1, 1'b0, 1'b0);   // back-to-back start
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

    // Input changes and start re-pulses during RUN/DONE are ignored.
    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("no_queued_start", busy, 1'b0);
    check("held_diff_idle", diff, 8'h02);

    // Reset after three RUN edges aborts the operation.
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);                       // after t0
    start = 1'b0;
    repeat (3) @(negedge clk);            // after t0+3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_diff", diff, '0);
    check("abort_bout", bout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_no_busy", busy, 1'b0);
    end
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
